button_debounce: RTL and testbench

Debounces the synchronized, active-high button level and produces clean single-cycle event pulses for the UART command/report logic. It sits between the button synchronizer and the button-press UART block, and replaces the bare rising-edge detect. Key outputs:
- press, release and long-press pulses;
- a debounced level;
- a wrapping press counter;
- a saturating bounce counter for diagnostics.

---
 rtl/button_debounce.sv | 126 ++++++++++++
 tb/tb_button_debounce.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Button debouncer: qualifies press/release over DEBOUNCE_CYCLES identical samples and
// emits single-cycle press, release and long-press pulses plus diagnostic counters.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic       clk_100mhz,
  input  logic       rst_n_sync,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count,
  output logic [7:0] bounce_count
);

  localparam int QW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [QW-1:0] Q_ONE  = QW'(1);
  localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t          r_state;
  logic [QW-1:0]   r_q_cnt;
  logic [HW-1:0]   r_h_cnt;
  logic [HW-1:0]   w_h_next;
  logic            w_long_edge;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [HW-1:0] hold_inc(input logic [HW-1:0] v);
    return (v == H_MAX) ? v : v + H_ONE;
  endfunction

  // Saturation of the hold counter is what limits long_pulse to once per press.
  assign w_h_next    = hold_inc(r_h_cnt);
  assign w_long_edge = (r_h_cnt == (H_MAX - H_ONE));

  always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_state       <= IDLE;
      r_q_cnt       <= '0;
      r_h_cnt       <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= 8'd0;
      bounce_count  <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (btn_in) begin
            r_state <= PRESS_WAIT;
            r_q_cnt <= Q_ONE;
          end else begin
            r_q_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (btn_in) begin
            if (r_q_cnt == Q_LAST) begin
              r_state     <= PRESSED;
              r_q_cnt     <= '0;
              r_h_cnt     <= H_ONE;
              btn_level   <= 1'b1;
              press_pulse <= 1'b1;
              press_count <= press_count + 8'd1;
            end else begin
              r_q_cnt <= r_q_cnt + Q_ONE;
            end
          end else begin
            r_state      <= IDLE;
            r_q_cnt      <= '0;
            bounce_count <= sat_inc8(bounce_count);
          end
        end
        PRESSED: begin
          r_h_cnt    <= w_h_next;
          long_pulse <= w_long_edge;
          if (!btn_in) begin
            r_state <= RELEASE_WAIT;
            r_q_cnt <= Q_ONE;
          end
        end
        RELEASE_WAIT: begin
          // The long threshold may land on the release-acceptance edge; both pulses fire.
          long_pulse <= w_long_edge;
          if (!btn_in) begin
            if (r_q_cnt == Q_LAST) begin
              r_state       <= IDLE;
              r_q_cnt       <= '0;
              r_h_cnt       <= '0;
              btn_level     <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              r_q_cnt <= r_q_cnt + Q_ONE;
              r_h_cnt <= w_h_next;
            end
          end else begin
            r_state      <= PRESSED;
            r_q_cnt      <= '0;
            r_h_cnt      <= w_h_next;
            bounce_count <= sat_inc8(bounce_count);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20: table-driven
// per-cycle vectors through a scoreboard queue, plus reset and counter corner sequences.
module tb_button_debounce;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;
  logic [7:0] bounce_count;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
  ) dut (
    .clk_100mhz   (clk),
    .rst_n_sync   (rst_n),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count),
    .bounce_count (bounce_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output nibble: {btn_level, press_pulse, release_pulse, long_pulse}
  localparam logic [3:0] E_0  = 4'b0000;
  localparam logic [3:0] E_L  = 4'b1000;
  localparam logic [3:0] E_P  = 4'b1100;
  localparam logic [3:0] E_R  = 4'b0010;
  localparam logic [3:0] E_LG = 4'b1001;
  localparam logic [3:0] E_RL = 4'b0011;

  typedef struct {
    logic       btn;
    logic [3:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] sb_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  function automatic void add(input logic b, input logic [3:0] e, input int n = 1);
    for (int i = 0; i < n; i++) tbl.push_back('{btn: b, exp: e});
  endfunction

  // Called between edges: drive, push expectation, compare just after the next rising edge.
  task automatic step(input string nm, input logic b, input logic [3:0] e);
    logic [3:0] want;
    btn_in = b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    chk(nm, {28'd0, btn_level, press_pulse, release_pulse, long_pulse}, {28'd0, want});
  endtask

  task automatic run_tbl(input string nm);
    for (int i = 0; i < tbl.size(); i++) step(nm, tbl[i].btn, tbl[i].exp);
    tbl.delete();
  endtask

  function automatic logic [31:0] all_out();
    return {12'd0, btn_level, press_pulse, release_pulse, long_pulse, press_count, bounce_count};
  endfunction

  // Asserts reset between edges, checks it takes effect without a clock, releases it
  // just after a rising edge so the following edge is the first post-reset sample.
  task automatic do_reset(input string nm, input logic b);
    btn_in = b;
    rst_n  = 1'b0;
    #1;
    chk({nm, "_async"}, all_out(), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk({nm, "_held"}, all_out(), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b0;
    #2;
    do_reset("reset0", 1'b0);

    // Clean press held 10 samples, then clean release: no long press.
    add(1, E_0, 3); add(1, E_P); add(1, E_L, 6);
    run_tbl("clean_press");
    chk("clean_press_count", press_count, 1);
    chk("clean_bounce_count", bounce_count, 0);
    add(0, E_L, 3); add(0, E_R); add(0, E_0, 2);
    run_tbl("clean_release");

    // Bouncy press 1,1,0,1,0,1,1,1,1
    do_reset("reset1", 1'b0);
    add(1, E_0, 2); add(0, E_0); add(1, E_0); add(0, E_0); add(1, E_0, 3); add(1, E_P);
    run_tbl("bouncy_press");
    chk("bouncy_press_count", press_count, 1);
    chk("bouncy_bounce_count", bounce_count, 2);

    // Release with a glitch 0,0,1,0,0,0,0
    add(0, E_L, 2); add(1, E_L); add(0, E_L, 3); add(0, E_R);
    run_tbl("bouncy_release");
    chk("bouncy_release_bounce", bounce_count, 3);
    chk("bouncy_release_count", press_count, 1);

    // Long press: 30 samples high, long_pulse 19 edges after press_pulse.
    do_reset("reset2", 1'b0);
    add(1, E_0, 3); add(1, E_P); add(1, E_L, 18); add(1, E_LG); add(1, E_L, 7);
    add(0, E_L, 3); add(0, E_R); add(0, E_0, 2);
    run_tbl("long_press");

    // Release acceptance coincides with the long threshold.
    do_reset("reset3", 1'b0);
    add(1, E_0, 3); add(1, E_P); add(1, E_L, 15); add(0, E_L, 3); add(0, E_RL); add(0, E_0, 2);
    run_tbl("coincident");

    // 256 presses: press_count wraps to 0 on the cycle of the last press_pulse.
    do_reset("reset4", 1'b0);
    for (int k = 1; k <= 256; k++) begin
      add(1, E_0, 3); add(1, E_P);
      run_tbl("wrap_press");
      chk("wrap_count", press_count, k & 255);
      add(0, E_L, 3); add(0, E_R);
      run_tbl("wrap_release");
    end

    // 260 aborted presses: bounce_count saturates at 255.
    do_reset("reset5", 1'b0);
    for (int k = 1; k <= 260; k++) begin
      add(1, E_0); add(0, E_0);
      run_tbl("bounce_sat_seq");
      chk("bounce_sat", bounce_count, (k > 255) ? 255 : k);
    end

    // Reset mid-hold clears everything at once; btn held high across release is a fresh press.
    do_reset("reset6", 1'b0);
    add(1, E_0); add(0, E_0); add(1, E_0, 3); add(1, E_P); add(1, E_L, 2);
    run_tbl("pre_hold_reset");
    chk("pre_hold_reset_counts", {press_count, bounce_count}, {8'd1, 8'd1});
    do_reset("hold_reset", 1'b1);
    add(1, E_0, 3); add(1, E_P);
    run_tbl("press_after_reset");
    chk("press_after_reset_count", press_count, 1);

    // Reset mid-PRESS_WAIT with btn held high.
    add(0, E_L, 3); add(0, E_R); add(1, E_0, 2);
    run_tbl("pre_pw_reset");
    do_reset("pw_reset", 1'b1);
    add(1, E_0, 3); add(1, E_P);
    run_tbl("press_after_pw_reset");
    chk("press_after_pw_reset_count", press_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
